cpu_phase_seq: RTL and testbench

- Sequencer that directly feeds the execute-stage ALU.
- Generates the one-hot five-phase strobe (F,R,X,M,W).
- Fetches one 32-bit instruction word per instruction over a req/ack port and holds it in the instruction register.
- Decodes the register-address fields, steps/redirects the PC, stalls in M for loads/stores and stops on HLT.

---
 rtl/cpu_phase_seq.sv | 183 ++++++++++++++++++
 tb/tb_cpu_phase_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_seq.sv
// -----------------------------------------------------------------------------
// cpu_phase_seq
//
// Five-phase instruction sequencer feeding the execute-stage ALU.
// Walks IDLE -> F -> R -> X -> M -> W -> F ... and parks in HALT on HLT.
// It fetches one 32-bit word per instruction, holds it in ir, and decodes the
// register-address fields. It also steps or redirects the PC and stalls in M
// for loads and stores.
//
// Optional feature (compile-time macro CPU_PHASE_SEQ_PERF_EN):
//   defined   -> retired_cnt counts W cycles (32-bit, wraps, cleared by rst)
//   undefined -> no counter is built, retired_cnt is tied to 0
//
// Parameters:
//   RESET_PC    PC value loaded on reset
//   PC_STEP     byte increment applied after each fetch
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous reset, active-high
//   imem_req     out  1   instruction fetch request (state F)
//   imem_addr    out  32  fetch address (= pc)
//   imem_ack     in   1   fetch complete, imem_rdata valid this cycle
//   imem_rdata   in   32  fetched instruction word
//   dmem_req     out  1   data access request (state M, load/store only)
//   dmem_we      out  1   1 = store, 0 = load, valid with dmem_req
//   dmem_ack     in   1   data access complete
//   br_taken     in   1   branch resolved taken, sampled in X only
//   br_target    in   32  branch destination, sampled with br_taken
//   phase        out  5   one-hot phase: bit4=F, 3=R, 2=X, 1=M, 0=W
//   ir           out  32  current instruction
//   ra1          out  3   register read address 1 = ir[18:16]
//   ra2          out  3   register read address 2 = ir[21:19]
//   pc           out  32  program counter
//   halted       out  1   HLT executed
//   retired_cnt  out  32  retired-instruction count
//
// Handshake (both memory ports): the request is a pure function of state and
// is held high until the cycle in which ack is seen. Ack in the same cycle the
// request first rises is legal and completes the transfer. Ack while the
// matching request is low is ignored.
//
// State visibility: phase is the one-hot image of F..W. halted marks HALT.
// phase == 0 with halted == 0 is IDLE.
// -----------------------------------------------------------------------------
module cpu_phase_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [4:0]  phase,
    output logic [31:0] ir,
    output logic [2:0]  ra1,
    output logic [2:0]  ra2,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F    = 3'd1,
        S_R    = 3'd2,
        S_X    = 3'd3,
        S_M    = 3'd4,
        S_W    = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [7:0] OP_HLT   = 8'hF4;
    localparam logic [7:0] OP_LOAD  = 8'h8A;
    localparam logic [7:0] OP_STORE = 8'h88;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] opcode;
    logic       is_load;
    logic       is_store;
    logic       is_ldst;

    assign opcode   = ir[31:24];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_ldst  = is_load | is_store;

    // Register-address decode is straight from ir, so it is valid from R on.
    assign ra1 = ir[18:16];
    assign ra2 = ir[21:19];

    assign imem_addr = pc;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_F;
            S_F:    state_nxt = imem_ack ? S_R : S_F;
            S_R:    state_nxt = (opcode == OP_HLT) ? S_HALT : S_X;
            S_X:    state_nxt = S_M;
            // Non-memory opcodes pass through M in a single cycle.
            S_M:    state_nxt = (!is_ldst || dmem_ack) ? S_W : S_M;
            S_W:    state_nxt = S_F;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        phase    = 5'b00000;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        halted   = 1'b0;
        case (state)
            S_F: begin
                phase    = 5'b10000;
                imem_req = 1'b1;
            end
            S_R: phase = 5'b01000;
            S_X: phase = 5'b00100;
            S_M: begin
                phase    = 5'b00010;
                dmem_req = is_ldst;
                dmem_we  = is_store;
            end
            S_W:    phase  = 5'b00001;
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    // --------------------------------------------------------- pc / ir datapath
    // pc is bumped at fetch completion. A taken branch in X then replaces that
    // already-incremented value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
            ir <= 32'h0000_0000;
        end else begin
            if (state == S_F && imem_ack) begin
                ir <= imem_rdata;
                pc <= pc + PC_STEP;
            end else if (state == S_X && br_taken) begin
                pc <= br_target;
            end
        end
    end

    // ------------------------------------------------------ retired counter
`ifdef CPU_PHASE_SEQ_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= 32'h0000_0000;
        end else if (state == S_W) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end
`else
    assign retired_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_cpu_phase_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_phase_seq
//
// Directed bench for cpu_phase_seq. Inputs are driven on the falling edge and
// outputs are checked on the falling edge, away from the active rising edge.
// Expected values are hand-computed from the intended behaviour.
// -----------------------------------------------------------------------------
module tb_cpu_phase_seq;

    // ---------------------------------------------------------- clock / reset
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        br_taken;
    logic [31:0] br_target;
    logic [4:0]  phase;
    logic [31:0] ir;
    logic [2:0]  ra1;
    logic [2:0]  ra2;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] retired_cnt;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cpu_phase_seq #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ack    (dmem_ack),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .phase       (phase),
        .ir          (ir),
        .ra1         (ra1),
        .ra2         (ra2),
        .pc          (pc),
        .halted      (halted),
        .retired_cnt (retired_cnt)
    );

    // ------------------------------------------------------------ checker
    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ drivers
    // One rising edge, then return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Returns on a falling edge with rst low and the DUT in IDLE.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        br_taken = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Load/store through M with two wait cycles before dmem_ack.
    task automatic run_mem(input string nm, input logic [31:0] word,
                           input logic exp_we);
        int m_cycles;
        do_reset();
        imem_rdata = word;
        imem_ack   = 1'b1;
        dmem_ack   = 1'b0;
        ticks(4);                         // IDLE -> F -> R -> X -> M
        m_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (phase == 5'b00010) m_cycles++;
            check_eq({nm, "_dmem_req"}, {31'd0, dmem_req}, 32'd1);
            check_eq({nm, "_dmem_we"},  {31'd0, dmem_we},  {31'd0, exp_we});
            if (i == 2) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0;
        check_eq({nm, "_m_cycles"}, m_cycles, 32'd3);
        check_eq({nm, "_w_phase"},  {27'd0, phase}, 32'h01);
        check_eq({nm, "_w_dreq"},   {31'd0, dmem_req}, 32'd0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [4:0]  exp_phase_q[$];
        logic [31:0] exp_ret;
        int          req_seen;
        int          dreq_seen;

        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h00C3_0000;
        dmem_ack   = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'h0;

        // --- reset values
        #2;
        check_eq("rst_phase",  {27'd0, phase}, 32'h0);
        check_eq("rst_pc",     pc, 32'h0);
        check_eq("rst_ir",     ir, 32'h0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_ireq",   {31'd0, imem_req}, 32'd0);
        check_eq("rst_dreq",   {31'd0, dmem_req}, 32'd0);
        check_eq("rst_dwe",    {31'd0, dmem_we}, 32'd0);
        check_eq("rst_retired", retired_cnt, 32'h0);

        // --- zero-wait ADD: phase sequence, pc step, decode
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_phase_q = '{5'b00000, 5'b10000, 5'b01000, 5'b00100,
                        5'b00010, 5'b00001, 5'b10000};
        dreq_seen = 0;
        while (exp_phase_q.size() > 0) begin
            check_eq("add_phase", {27'd0, phase}, {27'd0, exp_phase_q.pop_front()});
            if (dmem_req) dreq_seen++;
            if (phase == 5'b01000) begin
                check_eq("add_pc_r", pc, 32'h4);
                check_eq("add_ir",   ir, 32'h00C3_0000);
                check_eq("add_ra1",  {29'd0, ra1}, 32'd3);
                check_eq("add_ra2",  {29'd0, ra2}, 32'd0);
            end
            if (exp_phase_q.size() > 0) tick();
        end
        check_eq("add_dreq_never", dreq_seen, 32'd0);
        check_eq("add_next_addr", imem_addr, 32'h4);

        // --- imem_ack delayed 3 cycles
        do_reset();
        imem_ack   = 1'b0;
        imem_rdata = 32'h00C3_0000;
        tick();                           // now in F
        for (int i = 0; i < 4; i++) begin
            check_eq("wait_phase", {27'd0, phase}, 32'h10);
            check_eq("wait_ireq",  {31'd0, imem_req}, 32'd1);
            check_eq("wait_addr",  imem_addr, 32'h0);
            check_eq("wait_ir",    ir, 32'h0);
            if (i == 3) imem_ack = 1'b1;
            tick();
        end
        check_eq("wait_r_phase", {27'd0, phase}, 32'h08);
        check_eq("wait_r_ir",    ir, 32'h00C3_0000);
        check_eq("wait_r_pc",    pc, 32'h4);

        // --- load and store with two wait cycles
        run_mem("load",  32'h8A41_0000, 1'b0);
        run_mem("store", 32'h8841_0000, 1'b1);

        // --- taken branch in X
        do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'h00C3_0000;
        ticks(3);                         // IDLE -> F -> R -> X
        check_eq("br_x_phase", {27'd0, phase}, 32'h04);
        br_taken  = 1'b1;
        br_target = 32'h100;
        tick();                           // M
        br_taken  = 1'b0;
        check_eq("br_m_pc", pc, 32'h100);
        ticks(2);                         // W -> F
        check_eq("br_f_addr", imem_addr, 32'h100);

        // --- br_taken during R only is ignored
        do_reset();
        ticks(2);                         // IDLE -> F -> R
        br_taken  = 1'b1;
        br_target = 32'h200;
        tick();                           // X
        br_taken  = 1'b0;
        tick();                           // M
        check_eq("br_r_pc", pc, 32'h4);

        // --- HLT
        do_reset();
        imem_rdata = 32'hF400_0000;
        ticks(3);                         // IDLE -> F -> R -> HALT
        check_eq("hlt_phase",  {27'd0, phase}, 32'h0);
        check_eq("hlt_halted", {31'd0, halted}, 32'd1);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req || dmem_req) req_seen++;
            tick();
        end
        check_eq("hlt_no_req",  req_seen, 32'd0);
        check_eq("hlt_still",   {31'd0, halted}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("hlt_rst_pc",     pc, 32'h0);
        check_eq("hlt_rst_halted", {31'd0, halted}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // --- three ADDs then HLT: retired count
        do_reset();
        imem_rdata = 32'h00C3_0000;
        ticks(16);                        // IDLE->F, then 3 x (F R X M W)
        check_eq("ret_f_phase", {27'd0, phase}, 32'h10);
        imem_rdata = 32'hF400_0000;
        ticks(2);                         // R -> HALT
`ifdef CPU_PHASE_SEQ_PERF_EN
        exp_ret = 32'd3;
`else
        exp_ret = 32'd0;
`endif
        check_eq("ret_halted", {31'd0, halted}, 32'd1);
        check_eq("ret_count",  retired_cnt, exp_ret);
        check_eq("ret_pc",     pc, 32'h10);

        // --- async reset mid-M with dmem_req high
        do_reset();
        imem_rdata = 32'h8A41_0000;
        ticks(4);                         // M
        check_eq("amid_dreq_pre", {31'd0, dmem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("amid_dreq",  {31'd0, dmem_req}, 32'd0);
        check_eq("amid_phase", {27'd0, phase}, 32'h0);
        check_eq("amid_pc",    pc, 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        dmem_ack = 1'b1;                  // stale ack outside M
        imem_rdata = 32'h00C3_0000;
        tick();                           // F
        check_eq("amid_f_phase", {27'd0, phase}, 32'h10);
        check_eq("amid_f_dreq",  {31'd0, dmem_req}, 32'd0);
        dmem_ack = 1'b0;

        // ------------------------------------------------------- report
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
